// File: rtl/serial_frame_receiver.sv
// PS/2-style frame receiver: synchronise, debounce, fall-detect, then start/data/parity/stop FSM with timeout.
// Strobes rise DEBOUNCE_CYCLES+3 cycles after the raw stop-bit clock fall; no backpressure, words are simply overwritten.
module serial_frame_receiver #(
  parameter int DATA_BITS       = 8,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 5000,
  parameter bit PARITY_ODD      = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SERIAL_CLOCK,
  input  logic                 SERIAL_DATA,
  output logic [DATA_BITS-1:0] SCAN_CODE,
  output logic                 DATA_VALID,
  output logic                 PARITY_ERROR,
  output logic                 FRAME_ERROR,
  output logic                 TIMEOUT_ERROR,
  output logic                 BUSY
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Index 0 is the serial clock line, index 1 the serial data line.
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [DCW-1:0] deb_cnt [2];
  logic           clk_prev;
  logic           fall;
  logic           dat_db;

  state_t               state;
  logic [BCW-1:0]       bit_cnt;
  logic [TCW-1:0]       tmo_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 parity_ok;

  assign raw       = {SERIAL_DATA, SERIAL_CLOCK};
  assign fall      = clk_prev & ~deb[0];
  assign dat_db    = deb[1];
  assign parity_ok = ((^shift) ^ parity_bit) == PARITY_ODD;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      deb        <= 2'b11;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      clk_prev   <= 1'b1;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      clk_prev <= deb[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      shift         <= '0;
      parity_bit    <= 1'b0;
      SCAN_CODE     <= '0;
      DATA_VALID    <= 1'b0;
      PARITY_ERROR  <= 1'b0;
      FRAME_ERROR   <= 1'b0;
      TIMEOUT_ERROR <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      DATA_VALID    <= 1'b0;
      PARITY_ERROR  <= 1'b0;
      FRAME_ERROR   <= 1'b0;
      TIMEOUT_ERROR <= 1'b0;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;

      // A serial-clock fall always wins over an expiring timeout.
      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_db) begin
              state   <= DATA;
              bit_cnt <= '0;
              BUSY    <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {dat_db, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= dat_db;
            state      <= STOP;
          end
          STOP: begin
            if (!dat_db) begin
              FRAME_ERROR <= 1'b1;
            end else if (!parity_ok) begin
              PARITY_ERROR <= 1'b1;
            end else begin
              SCAN_CODE  <= shift;
              DATA_VALID <= 1'b1;
            end
            state <= IDLE;
            BUSY  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
        TIMEOUT_ERROR <= 1'b1;
        state         <= IDLE;
        BUSY          <= 1'b0;
        shift         <= '0;
        tmo_cnt       <= '0;
      end
    end
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Parametrised PS/2-style serial frame receiver on a single fast system clock. It replaces the separate slow-clock shift register with an integrated design:
- two-flop synchronisers and counter-based debounce on both serial lines;
- falling-edge detection of the serial clock;
- a frame state machine that checks start, parity, stop and inactivity timeout.

Received words are presented as a held parallel code with a one-cycle valid strobe and per-frame error strobes, for consumption by keyboard/I2C front-end logic.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5–16.
- DEBOUNCE_CYCLES, 8: consecutive stable CLK cycles required before a debounced line changes; ≥1.
- TIMEOUT_CYCLES, 5000: maximum CLK cycles between serial-clock falling edges inside a frame; ≥2.
- PARITY_ODD, 1: 1 = odd parity, 0 = even parity.
- CLK  in  1  single fast system clock; all logic is on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- SERIAL_CLOCK  in  1  raw, asynchronous serial clock line; idles high.
- SERIAL_DATA  in  1  raw, asynchronous serial data line; idles high.
- SCAN_CODE  out  DATA_BITS  last correctly received word; held until the next good frame.
- DATA_VALID  out  1  one-cycle pulse when SCAN_CODE updates.
- PARITY_ERROR  out  1  one-cycle pulse: parity bit wrong, stop bit good.
- FRAME_ERROR  out  1  one-cycle pulse: stop bit sampled low.
- TIMEOUT_ERROR  out  1  one-cycle pulse: frame abandoned on inactivity.
- BUSY  out  1  high whenever the state machine is not in IDLE.

## Operation
- **Synchroniser:** two flops per line; reset value 1.
- **Debounce (per line):**
  - The debounced output has reset value 1.
  - A counter increments while the synchronised input differs from the debounced output and clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES, the output takes the input value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- **Edge detect:** FALL = previous debounced clock AND NOT current debounced clock. Previous register resets to 1. FALL is high for exactly one cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. Every transition and sample happens only in a cycle where FALL=1, except timeout. Debounced data is sampled in the FALL cycle.
  - IDLE: data=0 → DATA, bit counter cleared. Data=1 (no start bit) → remain in IDLE, no flag.
  - DATA: shift right, new bit enters the MSB, counter increments. When the counter equals DATA_BITS-1 on a FALL → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP:
    - Evaluate ok = ^shift ^ parity_bit == PARITY_ODD.
    - Stop=0 → FRAME_ERROR only, even if parity is also bad.
    - Stop=1 and !ok → PARITY_ERROR.
    - Stop=1 and ok → SCAN_CODE <= shift, DATA_VALID.
    - Always → IDLE.
- **Timeout:**
  - The cycle counter clears on every FALL and while in IDLE, and increments otherwise.
  - On reaching TIMEOUT_CYCLES with no FALL that cycle: TIMEOUT_ERROR, → IDLE, shift contents discarded.
  - A FALL in the same cycle as expiry wins and is processed normally.
- **Error strobes** are mutually exclusive; at most one of DATA_VALID / PARITY_ERROR / FRAME_ERROR / TIMEOUT_ERROR is high in any cycle.
- **RST (including mid-frame):**
  - State → IDLE; SCAN_CODE=0; all strobes 0; BUSY=0.
  - Synchronisers, debounced lines and edge register → 1; all counters → 0.

## Timing
- A raw line change held stable appears on the debounced output DEBOUNCE_CYCLES+2 cycles later.
- FALL is asserted in that same cycle.
- All outputs are registered. DATA_VALID and the error strobes rise the cycle after the stop-bit FALL, i.e. DEBOUNCE_CYCLES+3 cycles after the raw stop-bit clock falling edge.
- SCAN_CODE changes in the same cycle DATA_VALID rises.
- BUSY rises the cycle after the start-bit FALL and falls together with the final strobe.
- Pulses on either raw line shorter than DEBOUNCE_CYCLES cycles are fully rejected.
- Data must be stable at the raw pins across the debounced clock fall: PS/2 mid-bit sampling satisfies this for bit periods ≥ 2·(DEBOUNCE_CYCLES+2).

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200, bit half-period 40 CLK cycles.
- **Good frame:** send 0x1C (LSB first 0,0,1,1,1,0,0,0), parity 0, stop 1 → SCAN_CODE=0x1C, DATA_VALID high exactly 1 cycle, 7 cycles after the raw stop fall; no errors.
- **Bad parity:** send 0x1C with parity 1 → PARITY_ERROR 1 cycle; SCAN_CODE holds its prior value; DATA_VALID stays 0.
- **Bad stop, and precedence:**
  - 0x1C with good parity, stop 0 → FRAME_ERROR only.
  - Repeat with bad parity as well → still FRAME_ERROR only.
- **Timeout and recovery:** stop after 5 data bits → TIMEOUT_ERROR 200 cycles after the last debounced fall, BUSY=0. Then send 0xF0 with parity 1 → SCAN_CODE=0xF0, DATA_VALID.
- **Glitch rejection:** 3-cycle low pulses on SERIAL_CLOCK in IDLE and mid-frame → no FALL, BUSY/state unchanged. The frame then completes with the correct code.
- **Reset mid-frame and wider words:**
  - Assert RST for 1 cycle after 4 data bits → BUSY=0, SCAN_CODE=0, no strobes. The next full frame is received correctly.
  - Rerun with DATA_BITS=9 → word 0x1A5 is received correctly.
